chip8_timer_unit: RTL and testbench

//  CPU-facing side of the Chip-8 delay and sound timers.
//  - FX15 / FX18 write the delay / sound timer; FX07 reads the delay timer back into VX.
//  - Derives its own 60 Hz tick from clk. Both 8-bit timers count down to zero on that tick.
//  - Reads use a req/ack handshake. beep drives the audio block.

---
 rtl/chip8_timer_unit_if.sv | 28 ++
 rtl/chip8_timer_unit.sv | 109 ++++++++++
 tb/tb_chip8_timer_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_timer_unit_if.sv
// CPU-side bus of the Chip-8 timer unit: timer write strobe and delay-timer read handshake.
// The CPU drives the master side; the timer unit sits on the slave side.
interface chip8_timer_unit_if;
    logic       wr_en;
    logic       wr_sel;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data,
        output rd_req,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  rd_req,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/chip8_timer_unit.sv
// Chip-8 delay and sound timers with a self-generated 60 Hz tick and a
// req/ack read path that returns the delay timer to the CPU (FX07).
module chip8_timer_unit #(
    parameter int unsigned TICK_DIV = 833_333,
    parameter int unsigned CNT_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    chip8_timer_unit_if.slave bus,
    output logic              delay_zero,
    output logic              beep,
    output logic              tick_60
);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACK,
        RD_HOLD
    } rd_state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             tick_q,    tick_d;
    logic [7:0]       delay_q,   delay_d;
    logic [7:0]       sound_q,   sound_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_ack_q,  rd_ack_d;
    rd_state_e        rd_state_q, rd_state_d;

    // Prescaler: free-running and never resynchronised by bus activity.
    always_comb begin
        // NOTE: every _d signal gets a default before any condition, so no path leaves it unassigned and infers a latch.
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // A write to a timer takes priority over a coincident tick for that timer only.
    always_comb begin
        delay_d = delay_q;
        sound_d = sound_q;
        if (tick_q) begin
            if (delay_q != 8'd0) delay_d = delay_q - 8'd1;
            if (sound_q != 8'd0) sound_d = sound_q - 8'd1;
        end
        if (bus.wr_en) begin
            if (bus.wr_sel) sound_d = bus.wr_data;
            else            delay_d = bus.wr_data;
        end
    end

    // Read handshake: one ack per assertion of rd_req, capturing the pre-edge delay value.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ack_d   = 1'b0;
        rd_data_d  = rd_data_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (bus.rd_req) begin
                    rd_data_d  = delay_q;
                    rd_ack_d   = 1'b1;
                    rd_state_d = RD_ACK;
                end
            end
            RD_ACK: begin
                rd_state_d = bus.rd_req ? RD_HOLD : RD_IDLE;
            end
            RD_HOLD: begin
                if (!bus.rd_req) rd_state_d = RD_IDLE;
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: rd_data is a single captured byte, so it is cleared with the rest of the state.
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            delay_q    <= 8'd0;
            sound_q    <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_ack_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            delay_q    <= delay_d;
            sound_q    <= sound_d;
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= rd_ack_d;
            rd_state_q <= rd_state_d;
        end
    end

    assign delay_zero  = (delay_q == 8'd0);
    assign beep        = (sound_q != 8'd0);
    assign tick_60     = tick_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_chip8_timer_unit.sv
// Self-checking bench for chip8_timer_unit with a fast prescaler; a cycle-level
// reference model built from the timer rules is compared against the DUT.
module tb_chip8_timer_unit;

    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    logic delay_zero;
    logic beep;
    logic tick_60;

    chip8_timer_unit_if bif ();

    chip8_timer_unit #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .delay_zero(delay_zero),
        .beep      (beep),
        .tick_60   (tick_60)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: m_cycle counts clock cycles since the last reset edge;
    // a tick falls on every nonzero multiple of TICK_DIV.
    int         m_cycle   = 0;
    logic [7:0] m_delay   = 8'd0;
    logic [7:0] m_sound   = 8'd0;
    logic [7:0] m_rd_data = 8'd0;
    bit         m_ack     = 1'b0;
    bit         m_served  = 1'b0;

    function automatic bit m_tick_now();
        return (m_cycle > 0) && (m_cycle % TICK_DIV == 0);
    endfunction

    task automatic step();
        bit tk;
        bit grant;
        tk = m_tick_now();
        if (reset) begin
            m_delay   = 8'd0;
            m_sound   = 8'd0;
            m_rd_data = 8'd0;
            m_ack     = 1'b0;
            m_served  = 1'b0;
            m_cycle   = 0;
        end else begin
            grant = bif.rd_req && !m_served;
            if (grant) m_rd_data = m_delay;
            if (!bif.rd_req) m_served = 1'b0;
            else if (grant)  m_served = 1'b1;
            if (bif.wr_en && !bif.wr_sel)  m_delay = bif.wr_data;
            else if (tk && m_delay != 0)   m_delay = m_delay - 8'd1;
            if (bif.wr_en && bif.wr_sel)   m_sound = bif.wr_data;
            else if (tk && m_sound != 0)   m_sound = m_sound - 8'd1;
            m_ack   = grant;
            m_cycle = m_cycle + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_timer(input bit sel, input logic [7:0] data);
        bif.wr_en   = 1'b1;
        bif.wr_sel  = sel;
        bif.wr_data = data;
        step();
        bif.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        int ticks;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        tests_run++;
        if (bif.rd_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_ack got %b want 0", bif.rd_ack); end
        tests_run++;
        if (bif.rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data got %h want 00", bif.rd_data); end
        tests_run++;
        if (delay_zero !== 1'b1) begin tests_failed++; $display("FAIL reset_delay_zero got %b want 1", delay_zero); end
        tests_run++;
        if (beep !== 1'b0) begin tests_failed++; $display("FAIL reset_beep got %b want 0", beep); end
        tests_run++;
        if (tick_60 !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %b want 0", tick_60); end
        ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (tick_60 === 1'b1) ticks++;
            tests_run++;
            if (tick_60 !== ((i % TICK_DIV) == 0)) begin
                tests_failed++;
                $display("FAIL tick_phase cycle %0d got %b want %b", i, tick_60, (i % TICK_DIV) == 0);
            end
        end
        tests_run++;
        if (ticks != 3) begin tests_failed++; $display("FAIL tick_count got %0d want 3", ticks); end
    endtask

    task automatic test_delay_countdown();
        int  ticks;
        int  rise_ticks;
        int  after_rise;
        int  bad_after;
        ticks      = 0;
        rise_ticks = -1;
        after_rise = 0;
        bad_after  = 0;
        write_timer(1'b0, 8'd8);
        tests_run++;
        if (delay_zero !== 1'b0) begin tests_failed++; $display("FAIL delay_loaded got %b want 0", delay_zero); end
        for (int i = 0; i < 60; i++) begin
            step();
            tests_run++;
            if (delay_zero !== (m_delay == 0)) begin
                tests_failed++;
                $display("FAIL delay_zero_track got %b want %b", delay_zero, m_delay == 0);
            end
            if (rise_ticks >= 0 && delay_zero !== 1'b1) bad_after++;
            if (rise_ticks < 0 && delay_zero === 1'b1) rise_ticks = ticks;
            if (tick_60 === 1'b1) begin
                ticks++;
                if (rise_ticks >= 0) after_rise++;
            end
        end
        tests_run++;
        if (rise_ticks != 8) begin tests_failed++; $display("FAIL delay_expire_tick got %0d want 8", rise_ticks); end
        tests_run++;
        if (after_rise < 3 || bad_after != 0) begin
            tests_failed++;
            $display("FAIL delay_no_underflow ticks_after %0d drops %0d want >=3 and 0", after_rise, bad_after);
        end
    endtask

    task automatic test_sound();
        int beep_ticks;
        beep_ticks = 0;
        write_timer(1'b1, 8'd3);
        tests_run++;
        if (beep !== 1'b1) begin tests_failed++; $display("FAIL sound_loaded got %b want 1", beep); end
        for (int i = 0; i < 24; i++) begin
            if (beep === 1'b1 && tick_60 === 1'b1) beep_ticks++;
            step();
            tests_run++;
            if (beep !== (m_sound != 0)) begin
                tests_failed++;
                $display("FAIL beep_track got %b want %b", beep, m_sound != 0);
            end
        end
        tests_run++;
        if (beep_ticks != 3 || beep !== 1'b0) begin
            tests_failed++;
            $display("FAIL beep_duration ticks %0d beep %b want 3 and 0", beep_ticks, beep);
        end
    endtask

    task automatic test_write_on_tick();
        write_timer(1'b1, 8'd10);
        for (int i = 0; i < TICK_DIV && !m_tick_now(); i++) step();
        tests_run++;
        if (tick_60 !== 1'b1) begin tests_failed++; $display("FAIL wr_tick_align got %b want 1", tick_60); end
        write_timer(1'b0, 8'd5);
        bif.rd_req = 1'b1;
        step();
        bif.rd_req = 1'b0;
        tests_run++;
        if (bif.rd_ack !== 1'b1 || bif.rd_data !== 8'd5) begin
            tests_failed++;
            $display("FAIL wr_beats_tick ack %b data %0d want 1 and 5", bif.rd_ack, bif.rd_data);
        end
        tests_run++;
        if (beep !== (m_sound != 0)) begin tests_failed++; $display("FAIL unselected_dec got %b want %b", beep, m_sound != 0); end
        for (int i = 0; i < 3; i++) step();
        bif.rd_req = 1'b1;
        step();
        bif.rd_req = 1'b0;
        tests_run++;
        if (bif.rd_ack !== 1'b1 || bif.rd_data !== 8'd4) begin
            tests_failed++;
            $display("FAIL delay_after_tick ack %b data %0d want 1 and 4", bif.rd_ack, bif.rd_data);
        end
        step();
    endtask

    task automatic test_read_hold();
        int acks;
        acks = 0;
        for (int i = 0; i < TICK_DIV && (m_cycle % TICK_DIV) != 1; i++) step();
        write_timer(1'b0, 8'h20);
        step();
        bif.rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bif.rd_ack === 1'b1) begin
                acks++;
                tests_run++;
                if (bif.rd_data !== 8'h20) begin tests_failed++; $display("FAIL hold_rd_data got %h want 20", bif.rd_data); end
            end
            tests_run++;
            if (bif.rd_ack !== m_ack) begin tests_failed++; $display("FAIL hold_ack_track got %b want %b", bif.rd_ack, m_ack); end
        end
        bif.rd_req = 1'b0;
        step();
        step();
        tests_run++;
        if (acks != 1 || bif.rd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_single_ack acks %0d ack %b want 1 and 0", acks, bif.rd_ack);
        end
    endtask

    task automatic test_reset_mid_read();
        bif.rd_req = 1'b1;
        step();
        tests_run++;
        if (bif.rd_ack !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_ack got %b want 1", bif.rd_ack); end
        reset = 1'b1;
        step();
        tests_run++;
        if (bif.rd_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ack got %b want 0", bif.rd_ack); end
        reset      = 1'b0;
        bif.rd_req = 1'b0;
        step();
        bif.rd_req = 1'b1;
        step();
        step();
        tests_run++;
        if (bif.rd_ack !== 1'b0) begin tests_failed++; $display("FAIL hold_no_ack got %b want 0", bif.rd_ack); end
        reset = 1'b1;
        step();
        tests_run++;
        if (bif.rd_ack !== 1'b0 || bif.rd_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_in_hold ack %b data %h want 0 and 00", bif.rd_ack, bif.rd_data);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (bif.rd_ack !== 1'b1) begin tests_failed++; $display("FAIL fresh_ack got %b want 1", bif.rd_ack); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bif.rd_ack !== 1'b0) begin tests_failed++; $display("FAIL fresh_single got %b want 0", bif.rd_ack); end
        end
        bif.rd_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bif.wr_en   = ($urandom_range(0, 6) == 0);
            bif.wr_sel  = 1'($urandom_range(0, 1));
            bif.wr_data = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            if ($urandom_range(0, 2) == 0) bif.rd_req = ~bif.rd_req;
            reset = ($urandom_range(0, 199) == 0);
            step();
            tests_run++;
            if (bif.rd_ack !== m_ack || bif.rd_data !== m_rd_data) begin
                tests_failed++;
                $display("FAIL rand_read cycle %0d ack %b data %h want %b %h", i, bif.rd_ack, bif.rd_data, m_ack, m_rd_data);
            end
            tests_run++;
            if (delay_zero !== (m_delay == 0) || beep !== (m_sound != 0) || tick_60 !== m_tick_now()) begin
                tests_failed++;
                $display("FAIL rand_status cycle %0d dz %b beep %b tick %b want %b %b %b",
                         i, delay_zero, beep, tick_60, m_delay == 0, m_sound != 0, m_tick_now());
            end
        end
        reset       = 1'b0;
        bif.wr_en   = 1'b0;
        bif.rd_req  = 1'b0;
        step();
    endtask

    initial begin
        reset       = 1'b1;
        bif.wr_en   = 1'b0;
        bif.wr_sel  = 1'b0;
        bif.wr_data = 8'd0;
        bif.rd_req  = 1'b0;
        test_reset();
        test_delay_countdown();
        test_sound();
        test_write_on_tick();
        test_read_hold();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
